bpsk_symbol_sequencer: RTL and testbench

Downstream consumer of the parallel-in shift buffer in the BPSK transmit path. After a word is loaded into the buffer, this block pulls one WIDTH-bit chunk at a time through the buffer's `read` strobe. It serialises each chunk LSB first into one BPSK symbol per bit and holds each symbol for SAMPLES_PER_BIT clocks. Its phase output drives the carrier phase select of the modulator/NCO stage.

---
 rtl/bpsk_pkg.sv | 18 +
 rtl/bpsk_symbol_sequencer_if.sv | 10 +
 rtl/bpsk_symbol_timer.sv | 59 +++++
 rtl/bpsk_symbol_sequencer.sv | 125 ++++++++++++
 tb/tb_bpsk_symbol_sequencer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/bpsk_pkg.sv
// Shared types and constants for the BPSK symbol sequencer.
package bpsk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SEND  = 2'd2
  } state_e;

  localparam logic PHASE_0   = 1'b0;
  localparam logic PHASE_180 = 1'b1;

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bpsk_symbol_sequencer_if.sv
// Chunk handshake between the parallel-in shift buffer and the symbol sequencer.
interface bpsk_symbol_sequencer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] buf_data;
  logic             buf_read;

  modport master (input buf_data, output buf_read);
  modport slave  (output buf_data, input buf_read);
endinterface

// File: rtl/bpsk_symbol_timer.sv
// Sample/bit counter pair for one chunk; exposes wrap flags and next-cycle lookahead.
module bpsk_symbol_timer
  import bpsk_pkg::*;
#(
  parameter int   SAMPLES_PER_BIT = 8,
  parameter int   WIDTH           = 4,
  localparam int  SW              = cnt_width(SAMPLES_PER_BIT),
  localparam int  BW              = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          adv,
  output logic [BW-1:0] nxt_bit,
  output logic          last_sample,
  output logic          last_bit,
  output logic          nxt_wrap
);

  localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLES_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(WIDTH - 1);

  logic [SW-1:0] sample_cnt;
  logic [SW-1:0] sample_nxt;
  logic [BW-1:0] bit_cnt;

  assign last_sample = (sample_cnt == SAMPLE_LAST);
  assign last_bit    = (bit_cnt == BIT_LAST);

  always_comb begin
    sample_nxt = sample_cnt;
    nxt_bit    = bit_cnt;
    if (clr) begin
      sample_nxt = '0;
      nxt_bit    = '0;
    end else if (adv) begin
      if (last_sample) begin
        sample_nxt = '0;
        nxt_bit    = last_bit ? '0 : bit_cnt + 1'b1;
      end else begin
        sample_nxt = sample_cnt + 1'b1;
      end
    end
  end

  // Lets the sequencer register outputs that belong to the final sample of a chunk.
  assign nxt_wrap = (sample_nxt == SAMPLE_LAST) && (nxt_bit == BIT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      bit_cnt    <= '0;
    end else begin
      sample_cnt <= sample_nxt;
      bit_cnt    <= nxt_bit;
    end
  end

endmodule

// File: rtl/bpsk_symbol_sequencer.sv
// Pulls WIDTH-bit chunks from the shift buffer and emits LSB-first BPSK symbols.
// Define BPSK_DIFFERENTIAL_EN for differential (DBPSK) phase encoding.
module bpsk_symbol_sequencer
  import bpsk_pkg::*;
#(
  parameter int WORD_SIZE       = 16,
  parameter int WIDTH           = 4,
  parameter int SAMPLES_PER_BIT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  bpsk_symbol_sequencer_if.master  bus,
  output logic                     busy,
  output logic                     done,
  output logic                     sym_valid,
  output logic                     sym_strobe,
  output logic                     phase
);

  localparam int NCH = WORD_SIZE / WIDTH;
  localparam int CW  = cnt_width(NCH);
  localparam int BW  = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCH - 1);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_LATCH = ST_LATCH;
  localparam logic [1:0] S_SEND  = ST_SEND;

  if (WORD_SIZE % WIDTH != 0) begin : g_bad_ratio
    $error("WORD_SIZE must be a multiple of WIDTH");
  end
  if (SAMPLES_PER_BIT < 1) begin : g_bad_spb
    $error("SAMPLES_PER_BIT must be at least 1");
  end

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] chunk_reg;
  logic [CW-1:0]    chunk_cnt, chunk_nxt;
  logic [BW-1:0]    nxt_bit;
  logic             last_sample, last_bit, nxt_wrap;
  logic             tmr_clr, tmr_adv;
  logic             chunk_end, prefetch, word_end, load_chunk;
  logic             enters_symbol, sym_bit_nxt, read_nxt;

  bpsk_symbol_timer #(
    .SAMPLES_PER_BIT (SAMPLES_PER_BIT),
    .WIDTH           (WIDTH)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (tmr_clr),
    .adv         (tmr_adv),
    .nxt_bit     (nxt_bit),
    .last_sample (last_sample),
    .last_bit    (last_bit),
    .nxt_wrap    (nxt_wrap)
  );

  assign chunk_end     = (state == S_SEND) && last_sample && last_bit;
  assign prefetch      = chunk_end && (chunk_cnt != LAST_CHUNK);
  assign word_end      = chunk_end && (chunk_cnt == LAST_CHUNK);
  assign load_chunk    = (state == S_LATCH) || prefetch;
  assign enters_symbol = (state == S_LATCH) || ((state == S_SEND) && last_sample && !word_end);
  // A freshly loaded chunk is not in chunk_reg yet, so its first bit comes straight off the bus.
  assign sym_bit_nxt   = load_chunk ? bus.buf_data[0] : chunk_reg[nxt_bit];

  always_comb begin
    state_nxt = state;
    chunk_nxt = chunk_cnt;
    tmr_clr   = 1'b0;
    tmr_adv   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LATCH;
      end
      S_LATCH: begin
        state_nxt = S_SEND;
        chunk_nxt = '0;
        tmr_clr   = 1'b1;
      end
      S_SEND: begin
        tmr_adv = 1'b1;
        if (prefetch) chunk_nxt = chunk_cnt + 1'b1;
        if (word_end) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // buf_read is registered, so it is raised one cycle ahead of the final sample of a chunk.
  assign read_nxt = (state_nxt == S_LATCH) ||
                    ((state_nxt == S_SEND) && nxt_wrap && (chunk_nxt != LAST_CHUNK));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      chunk_cnt    <= '0;
      chunk_reg    <= '0;
      phase        <= PHASE_0;
      bus.buf_read <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sym_valid    <= 1'b0;
      sym_strobe   <= 1'b0;
    end else begin
      state        <= state_nxt;
      chunk_cnt    <= chunk_nxt;
      bus.buf_read <= read_nxt;
      busy         <= (state_nxt != S_IDLE);
      done         <= word_end;
      sym_valid    <= (state_nxt == S_SEND);
      sym_strobe   <= enters_symbol;
      if (load_chunk) chunk_reg <= bus.buf_data;
      if (enters_symbol) begin
`ifdef BPSK_DIFFERENTIAL_EN
        phase <= (phase ^ sym_bit_nxt) ? PHASE_180 : PHASE_0;
`else
        phase <= sym_bit_nxt ? PHASE_180 : PHASE_0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_bpsk_symbol_sequencer.sv
// Directed bench for bpsk_symbol_sequencer with a shift-buffer model and symbol scoreboard.
module tb_bpsk_symbol_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n  = 1'b0;
  logic start8 = 1'b0;
  logic start1 = 1'b0;
  logic busy8, done8, valid8, strobe8, phase8;
  logic busy1, done1, valid1, strobe1, phase1;

  bpsk_symbol_sequencer_if #(.WIDTH(4)) bus8 ();
  bpsk_symbol_sequencer_if #(.WIDTH(4)) bus1 ();

  bpsk_symbol_sequencer #(.WORD_SIZE(16), .WIDTH(4), .SAMPLES_PER_BIT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .bus(bus8),
    .busy(busy8), .done(done8), .sym_valid(valid8), .sym_strobe(strobe8), .phase(phase8)
  );

  bpsk_symbol_sequencer #(.WORD_SIZE(16), .WIDTH(4), .SAMPLES_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bus(bus1),
    .busy(busy1), .done(done1), .sym_valid(valid1), .sym_strobe(strobe1), .phase(phase1)
  );

  // Parallel-in shift buffer models
  logic [15:0] word8 = '0, word1 = '0, lval8 = '0, lval1 = '0;
  logic        load8 = 1'b0, load1 = 1'b0;
  always @(posedge clk) begin
    if (load8) word8 <= lval8;
    else if (bus8.buf_read) word8 <= word8 >> 4;
    if (load1) word1 <= lval1;
    else if (bus1.buf_read) word1 <= word1 >> 4;
  end
  assign bus8.buf_data = word8[3:0];
  assign bus1.buf_data = word1[3:0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];
  logic ref_ph = 1'b0;
  logic last_exp = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor for the 8-samples-per-bit instance
  int t0_8 = 0, vcnt8 = 0, scnt8 = 0;
  int rd8[$];
  int dn8[$];
  always @(negedge clk) begin
    if (bus8.buf_read) rd8.push_back(cyc - t0_8);
    if (done8) dn8.push_back(cyc - t0_8);
    if (valid8) vcnt8++;
    if (valid8 && strobe8) begin
      scnt8++;
      if (exp_q.size() == 0) check("sym_unexpected", 32'd1, 32'd0);
      else check("sym_phase", 32'(phase8), 32'(exp_q.pop_front()));
    end
  end

  // Monitor for the 1-sample-per-bit instance
  int t0_1 = 0, v1_first = -1, v1_last = -1, v1cnt = 0, s1cnt = 0;
  int dn1[$];
  always @(negedge clk) begin
    if (valid1) begin
      if (v1_first < 0) v1_first = cyc - t0_1;
      v1_last = cyc - t0_1;
      v1cnt++;
    end
    if (strobe1) s1cnt++;
    if (done1) dn1.push_back(cyc - t0_1);
  end

  task automatic push_word(input logic [15:0] w);
    for (int i = 0; i < 16; i++) begin
`ifdef BPSK_DIFFERENTIAL_EN
      ref_ph = ref_ph ^ w[i];
      exp_q.push_back(ref_ph);
      last_exp = ref_ph;
`else
      exp_q.push_back(w[i]);
      last_exp = w[i];
`endif
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    ref_ph = 1'b0;
    exp_q.delete();
  endtask

  task automatic start_word8(input logic [15:0] w, input int hold);
    @(negedge clk);
    lval8 = w;
    load8 = 1'b1;
    @(negedge clk);
    load8 = 1'b0;
    rd8.delete();
    dn8.delete();
    vcnt8 = 0;
    scnt8 = 0;
    push_word(w);
    t0_8   = cyc;
    start8 = 1'b1;
    repeat (hold) @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_until8(input int rel);
    while (cyc - t0_8 < rel) @(negedge clk);
  endtask

  task automatic wait_done8(input int budget);
    int n = 0;
    while (!done8 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(done8), 32'd1);
    check("done_cycle", 32'(cyc - t0_8), 32'd130);
    check("busy_at_done", 32'(busy8), 32'd0);
    check("valid_at_done", 32'(valid8), 32'd0);
  endtask

  task automatic check_word8();
    @(negedge clk);
    check("read_count", 32'(rd8.size()), 32'd4);
    for (int i = 0; i < rd8.size() && i < 4; i++)
      check("read_cycle", 32'(rd8[i]), 32'(1 + 32 * i));
    check("done_count", 32'(dn8.size()), 32'd1);
    check("valid_cycles", 32'(vcnt8), 32'd128);
    check("strobe_count", 32'(scnt8), 32'd16);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // Reset then idle
    do_reset();
    rd8.delete();
    repeat (20) @(negedge clk);
    check("idle_outputs8", 32'({busy8, done8, valid8, strobe8, phase8, bus8.buf_read}), 32'd0);
    check("idle_outputs1", 32'({busy1, done1, valid1, strobe1, phase1, bus1.buf_read}), 32'd0);
    check("idle_reads", 32'(rd8.size()), 32'd0);

    // Full word 0xA5C3
    start_word8(16'hA5C3, 1);
    wait_done8(200);
    check_word8();
    repeat (3) @(negedge clk);
    check("phase_hold", 32'(phase8), 32'(last_exp));
    check("valid_after", 32'(valid8), 32'd0);

    // Word 0x0003 from phase 0
    do_reset();
    start_word8(16'h0003, 1);
    wait_done8(200);
    check_word8();

    // start held during busy and re-pulsed mid-word
    start_word8(16'h5A3C, 40);
    wait_until8(60);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(200);
    repeat (20) @(negedge clk);
    check("held_read_count", 32'(rd8.size()), 32'd4);
    check("held_done_count", 32'(dn8.size()), 32'd1);
    check("held_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-word, then replay
    start_word8(16'h1234, 1);
    wait_until8(50);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_outputs", 32'({busy8, done8, valid8, strobe8, phase8, bus8.buf_read}), 32'd0);
    rst_n  = 1'b1;
    ref_ph = 1'b0;
    exp_q.delete();
    start_word8(16'h1234, 1);
    wait_done8(200);
    check_word8();

    // One sample per bit
    @(negedge clk);
    lval1 = 16'hFFFF;
    load1 = 1'b1;
    @(negedge clk);
    load1    = 1'b0;
    v1_first = -1;
    v1_last  = -1;
    v1cnt    = 0;
    s1cnt    = 0;
    dn1.delete();
    t0_1   = cyc;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int n = 0; n < 60 && dn1.size() == 0; n++) @(negedge clk);
    @(negedge clk);
    check("spb1_done_count", 32'(dn1.size()), 32'd1);
    if (dn1.size() > 0) check("spb1_done_cycle", 32'(dn1[0]), 32'd18);
    check("spb1_valid_first", 32'(v1_first), 32'd2);
    check("spb1_valid_last", 32'(v1_last), 32'd17);
    check("spb1_valid_cycles", 32'(v1cnt), 32'd16);
    check("spb1_strobes", 32'(s1cnt), 32'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
